// File: rtl/fifo_pkt_sync.sv
// Packet-aware synchronous FIFO: words stay speculative until EOP commits them; partial packets can be discarded.
// Optional `FIFO_PKT_SYNC_STATS_EN builds a saturating dropped-packet counter on drop_cnt.
module fifo_pkt_sync #(
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned POINTER_WIDTH = 6,
   parameter int unsigned AFULL_THRESH  = 56
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DATA_WIDTH-1:0]    data_in,
   input  logic                     push,
   input  logic                     eop,
   input  logic                     discard,
   input  logic                     pop,
   output logic [DATA_WIDTH-1:0]    data_out,
   output logic                     data_out_eop,
   output logic                     empty,
   output logic                     full,
   output logic                     afull,
   output logic [POINTER_WIDTH:0]   level,
   output logic [POINTER_WIDTH:0]   pkt_cnt,
   output logic                     drop,
   output logic [15:0]              drop_cnt
);

   localparam int unsigned PTR_W = POINTER_WIDTH + 1;
   localparam int unsigned DEPTH = 2 ** POINTER_WIDTH;
   localparam int unsigned MEM_W = DATA_WIDTH + 1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_IN_PKT = 2'd1;
   localparam logic [1:0] ST_DROP   = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [PTR_W-1:0] rd_q, rd_d;
   logic [PTR_W-1:0] wr_cmt_q, wr_cmt_d;
   logic [PTR_W-1:0] wr_spec_q, wr_spec_d;
   logic [PTR_W-1:0] pkt_cnt_q, pkt_cnt_d;
   logic             drop_q, drop_d;
   logic [PTR_W-1:0] spec_occ;
   logic             wr_en;
   logic             rd_en;
   logic             commit;
   logic             pop_eop;
   logic [MEM_W-1:0] rd_word;

   logic [MEM_W-1:0] mem [DEPTH];

   // Occupancy flags derive from registered pointers only.
   assign spec_occ = wr_spec_q - rd_q;
   assign empty    = (wr_cmt_q == rd_q);
   assign full     = (spec_occ == PTR_W'(DEPTH));
   assign afull    = (spec_occ >= PTR_W'(AFULL_THRESH));
   assign level    = wr_cmt_q - rd_q;
   assign pkt_cnt  = pkt_cnt_q;
   assign drop     = drop_q;

   // Show-ahead read port.
   assign rd_word      = mem[rd_q[POINTER_WIDTH-1:0]];
   assign data_out     = rd_word[DATA_WIDTH-1:0];
   assign data_out_eop = rd_word[DATA_WIDTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_spec_q[POINTER_WIDTH-1:0]] <= {eop, data_in};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         rd_q      <= '0;
         wr_cmt_q  <= '0;
         wr_spec_q <= '0;
         pkt_cnt_q <= '0;
         drop_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rd_q      <= rd_d;
         wr_cmt_q  <= wr_cmt_d;
         wr_spec_q <= wr_spec_d;
         pkt_cnt_q <= pkt_cnt_d;
         drop_q    <= drop_d;
      end
   end

   // Write-side packet state machine; discard always wins over a same-cycle push.
   always_comb begin
      state_d   = state_q;
      wr_spec_d = wr_spec_q;
      wr_cmt_d  = wr_cmt_q;
      drop_d    = 1'b0;
      wr_en     = 1'b0;
      commit    = 1'b0;
      case (state_q)
         ST_IDLE, ST_IN_PKT: begin
            if (discard) begin
               wr_spec_d = wr_cmt_q;
               drop_d    = (wr_spec_q != wr_cmt_q);
               state_d   = ST_IDLE;
            end else if (push && full) begin
               // An overflowing EOP word terminates the doomed packet at once.
               if (eop) begin
                  wr_spec_d = wr_cmt_q;
                  drop_d    = 1'b1;
                  state_d   = ST_IDLE;
               end else begin
                  state_d = ST_DROP;
               end
            end else if (push) begin
               wr_en     = 1'b1;
               wr_spec_d = wr_spec_q + PTR_W'(1);
               if (eop) begin
                  wr_cmt_d = wr_spec_q + PTR_W'(1);
                  commit   = 1'b1;
                  state_d  = ST_IDLE;
               end else begin
                  state_d = ST_IN_PKT;
               end
            end
         end
         ST_DROP: begin
            if (discard || (push && eop)) begin
               wr_spec_d = wr_cmt_q;
               drop_d    = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            wr_spec_d = wr_cmt_q;
         end
      endcase
   end

   // Read side and packet accounting.
   always_comb begin
      rd_en     = pop && !empty;
      pop_eop   = rd_en && rd_word[DATA_WIDTH];
      rd_d      = rd_q + PTR_W'(rd_en);
      pkt_cnt_d = pkt_cnt_q;
      case ({commit, pop_eop})
         2'b10:   pkt_cnt_d = pkt_cnt_q + PTR_W'(1);
         2'b01:   pkt_cnt_d = pkt_cnt_q - PTR_W'(1);
         default: pkt_cnt_d = pkt_cnt_q;
      endcase
   end

`ifdef FIFO_PKT_SYNC_STATS_EN
   logic [15:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop_q && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_cnt_q <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_cnt = drop_cnt_q;
`else
   assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_pkt_sync.sv
// Self-checking bench for fifo_pkt_sync: queue-based packet model checked every cycle plus literal spot checks.
module tb_fifo_pkt_sync;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  data_in;
   logic        push, eop, discard, pop;
   logic [7:0]  data_out;
   logic        data_out_eop, empty, full, afull, drop;
   logic [4:0]  level, pkt_cnt;
   logic [15:0] drop_cnt;

   int tests = 0;
   int fails = 0;
   int cycle = 0;

   // Model: committed words, speculative words of the open packet, drop mode.
   logic [8:0] cq[$];
   logic [8:0] pq[$];
   bit         dropping;
   bit         drop_m;
   int         dcnt;

   fifo_pkt_sync #(.DATA_WIDTH(8), .POINTER_WIDTH(4), .AFULL_THRESH(12)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .push(push), .eop(eop),
      .discard(discard), .pop(pop), .data_out(data_out), .data_out_eop(data_out_eop),
      .empty(empty), .full(full), .afull(afull), .level(level), .pkt_cnt(pkt_cnt),
      .drop(drop), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %0d (0x%0h) expected %0d (0x%0h)", nm, cycle, act, act, exp, exp);
      end
   endtask

   task automatic model_reset();
      cq.delete();
      pq.delete();
      dropping = 0;
      drop_m   = 0;
      dcnt     = 0;
   endtask

   function automatic int count_pkts();
      int n = 0;
      foreach (cq[i]) if (cq[i][8]) n++;
      return n;
   endfunction

   task automatic model_step();
      bit was_full;
      bit was_empty;
      logic [8:0] w;
      if (rst) begin
         model_reset();
         return;
      end
      was_full  = (cq.size() + pq.size()) == 16;
      was_empty = (cq.size() == 0);
`ifdef FIFO_PKT_SYNC_STATS_EN
      if (drop_m && dcnt != 65535) dcnt++;
`endif
      drop_m = 0;
      if (pop && !was_empty) w = cq.pop_front();
      if (dropping) begin
         if (discard || (push && eop)) begin
            pq.delete();
            drop_m   = 1;
            dropping = 0;
         end
      end else if (discard) begin
         if (pq.size() > 0) drop_m = 1;
         pq.delete();
      end else if (push) begin
         if (was_full) begin
            if (eop) begin
               pq.delete();
               drop_m = 1;
            end else begin
               dropping = 1;
            end
         end else begin
            pq.push_back({eop, data_in});
            if (eop) begin
               foreach (pq[i]) cq.push_back(pq[i]);
               pq.delete();
            end
         end
      end
   endtask

   task automatic compare();
      int occ;
      occ = cq.size() + pq.size();
      chk("empty", int'(empty), int'(cq.size() == 0));
      chk("full", int'(full), int'(occ == 16));
      chk("afull", int'(afull), int'(occ >= 12));
      chk("level", int'(level), cq.size());
      chk("pkt_cnt", int'(pkt_cnt), count_pkts());
      chk("drop", int'(drop), int'(drop_m));
      chk("drop_cnt", int'(drop_cnt), dcnt);
      if (cq.size() > 0) begin
         chk("data_out", int'(data_out), int'(cq[0][7:0]));
         chk("data_out_eop", int'(data_out_eop), int'(cq[0][8]));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      cycle++;
      @(negedge clk);
      compare();
   endtask

   task automatic push_w(input logic [7:0] d, input logic e);
      data_in = d;
      eop     = e;
      push    = 1'b1;
      tick();
      push    = 1'b0;
      eop     = 1'b0;
   endtask

   task automatic pop_w();
      pop = 1'b1;
      tick();
      pop = 1'b0;
   endtask

   int exp_dc;

   initial begin
      rst = 1'b1; data_in = '0; push = 0; eop = 0; discard = 0; pop = 0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_empty", int'(empty), 1);
      chk("rst_full", int'(full), 0);
      chk("rst_afull", int'(afull), 0);
      chk("rst_level", int'(level), 0);
      chk("rst_pkt_cnt", int'(pkt_cnt), 0);
      chk("rst_drop", int'(drop), 0);
      chk("rst_drop_cnt", int'(drop_cnt), 0);
      rst = 1'b0;
      tick();

      // 3-word packet: invisible until the EOP word is in.
      push_w(8'h11, 0); chk("t1_empty_a", int'(empty), 1);
      push_w(8'h22, 0); chk("t1_empty_b", int'(empty), 1);
      push_w(8'h33, 1);
      chk("t1_level", int'(level), 3);
      chk("t1_pkt", int'(pkt_cnt), 1);
      chk("t1_dout0", int'(data_out), 8'h11);
      pop_w(); chk("t1_dout1", int'(data_out), 8'h22);
      pop_w(); chk("t1_dout2", int'(data_out), 8'h33); chk("t1_eop2", int'(data_out_eop), 1);
      pop_w(); chk("t1_pkt_end", int'(pkt_cnt), 0); chk("t1_empty_end", int'(empty), 1);

      // 5 partial words then discard, then a clean 2-word packet.
      for (int i = 0; i < 5; i++) push_w(8'hA0 + 8'(i), 0);
      discard = 1; tick(); discard = 0;
      chk("t2_drop", int'(drop), 1);
      chk("t2_level", int'(level), 0);
      chk("t2_empty", int'(empty), 1);
      tick(); chk("t2_drop_off", int'(drop), 0);
      push_w(8'h55, 0);
      push_w(8'h66, 1);
      chk("t2_dout0", int'(data_out), 8'h55);
      pop_w(); chk("t2_dout1", int'(data_out), 8'h66); chk("t2_eop1", int'(data_out_eop), 1);
      pop_w(); chk("t2_empty_end", int'(empty), 1);

      // Overflow: 10 committed, then a second packet overruns the FIFO.
      for (int i = 0; i < 10; i++) push_w(8'(i), (i == 9));
      chk("t3_level10", int'(level), 10);
      push_w(8'h10, 0); chk("t3_afull11", int'(afull), 0);
      push_w(8'h11, 0); chk("t3_afull12", int'(afull), 1);
      push_w(8'h12, 0);
      push_w(8'h13, 0);
      push_w(8'h14, 0); chk("t3_full15", int'(full), 0);
      push_w(8'h15, 0); chk("t3_full16", int'(full), 1);
      push_w(8'h16, 0); chk("t3_drop_none", int'(drop), 0);
      push_w(8'h17, 0);
      push_w(8'h18, 1);
      chk("t3_drop", int'(drop), 1);
      chk("t3_level", int'(level), 10);
      chk("t3_pkt", int'(pkt_cnt), 1);
      chk("t3_full_clr", int'(full), 0);
      chk("t3_dout", int'(data_out), 8'h00);
      for (int i = 0; i < 10; i++) pop_w();
      chk("t3_empty_end", int'(empty), 1);

      // Wrap-around: 4 rounds of 12-word packets.
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 12; i++) push_w(8'(r * 16 + i), (i == 11));
         chk("t4_level12", int'(level), 12);
         for (int i = 0; i < 12; i++) pop_w();
         chk("t4_level0", int'(level), 0);
      end

      // Pop of a stored 1-word packet alongside a new 1-word packet.
      push_w(8'h77, 1);
      data_in = 8'h88; eop = 1; push = 1; pop = 1;
      tick();
      push = 0; eop = 0; pop = 0;
      chk("t5_pkt", int'(pkt_cnt), 1);
      chk("t5_level", int'(level), 1);
      chk("t5_dout", int'(data_out), 8'h88);
      pop_w();

      // Discard overrides a same-cycle push&eop; discard in IDLE is silent.
      push_w(8'h01, 0);
      data_in = 8'h02; push = 1; eop = 1; discard = 1;
      tick();
      push = 0; eop = 0; discard = 0;
      chk("t6_drop", int'(drop), 1);
      chk("t6_level", int'(level), 0);
      discard = 1; tick(); discard = 0;
      chk("t6_idle_discard", int'(drop), 0);
      tick();
`ifdef FIFO_PKT_SYNC_STATS_EN
      exp_dc = 3;
`else
      exp_dc = 0;
`endif
      chk("t6_drop_cnt", int'(drop_cnt), exp_dc);

      // Reset with 3 committed and 4 speculative words stored.
      push_w(8'h31, 0); push_w(8'h32, 0); push_w(8'h33, 1);
      for (int i = 0; i < 4; i++) push_w(8'h34 + 8'(i), 0);
      chk("t7_pre_level", int'(level), 3);
      #2 rst = 1'b1;
      model_reset();
      #1;
      chk("t7_empty", int'(empty), 1);
      chk("t7_level", int'(level), 0);
      chk("t7_pkt", int'(pkt_cnt), 0);
      chk("t7_drop_cnt", int'(drop_cnt), 0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      push_w(8'hC1, 1);
      chk("t7_post_dout", int'(data_out), 8'hC1);
      pop_w();
      chk("t7_post_empty", int'(empty), 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
